// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Hazard unit between decode (ID) and issue of the in-order pipeline.
//   A shift-register scoreboard remembers the destination register of every
//   instruction issued during the last PIPE_DEPTH cycles. Stall and flush are
//   derived combinationally from the scoreboard and a small control-transfer
//   state machine. Two saturating counters record data and control stall cycles.
//
// Ports
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   id_valid       in   ID holds a valid instruction
//   id_rs1_en/rs1  in   ID reads rs1 / rs1 address
//   id_rs2_en/rs2  in   ID reads rs2 / rs2 address
//   id_rd_en/rd    in   ID writes rd / rd address
//   id_is_load     in   ID instruction is a load (result available late)
//   id_is_ctrl     in   ID instruction redirects the PC
//   ex_redirect    in   control target resolved this cycle (early release)
//   stall          out  hold IF/ID, bubble into EX
//   flush          out  one-cycle squash pulse when a control block releases
//   issue          out  ID instruction advances this cycle
//   data_stall_cnt out  saturating count of data-hazard stall cycles
//   ctrl_stall_cnt out  saturating count of control-hazard stall cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter int REG_AW     = 4,
   parameter int PIPE_DEPTH = 3,
   parameter int FORWARD_EN = 0,
   parameter int CTRL_LAT   = 3,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic              id_rs1_en,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic              id_rs2_en,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rd_en,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_is_load,
   input  logic              id_is_ctrl,
   input  logic              ex_redirect,
   output logic              stall,
   output logic              flush,
   output logic              issue,
   output logic [CNT_W-1:0]  data_stall_cnt,
   output logic [CNT_W-1:0]  ctrl_stall_cnt
);

   localparam int CW = (CTRL_LAT > 1) ? $clog2(CTRL_LAT) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   localparam logic [CW-1:0]    CNT_INIT  = CW'(CTRL_LAT - 1);
   localparam logic [CW-1:0]    CNT_ONE   = CW'(1'b1);
   localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
   localparam logic [CNT_W-1:0] PERF_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] PERF_MAX  = {CNT_W{1'b1}};
   localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

   // Scoreboard: slot 0 = EX, higher slots are older.
   logic [PIPE_DEPTH-1:0]             sb_vld_q, sb_vld_d;
   logic [PIPE_DEPTH-1:0]             sb_ld_q,  sb_ld_d;
   logic [PIPE_DEPTH-1:0][REG_AW-1:0] sb_rd_q,  sb_rd_d;

   logic [0:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [CNT_W-1:0] dcnt_q,  dcnt_d;
   logic [CNT_W-1:0] ccnt_q,  ccnt_d;

   logic data_haz_s;
   logic ctrl_haz_s;
   logic release_s;
   logic stall_s;
   logic issue_s;
   logic flush_s;

   // Hazard check for one source operand. With forwarding only a load sitting
   // in EX is too late to forward, so only slot 0 matters.
   function automatic logic src_hazard(
      input logic                             en,
      input logic [REG_AW-1:0]                rs,
      input logic [PIPE_DEPTH-1:0]            vld,
      input logic [PIPE_DEPTH-1:0]            ld,
      input logic [PIPE_DEPTH-1:0][REG_AW-1:0] rd
   );
      logic hit;
      hit = 1'b0;
      if (en && (rs != REG_ZERO)) begin
         if (FORWARD_EN != 0) begin
            hit = vld[0] && ld[0] && (rd[0] == rs);
         end else begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
               if (vld[i] && (rd[i] == rs)) begin
                  hit = 1'b1;
               end else begin
                  hit = hit;
               end
            end
         end
      end else begin
         hit = 1'b0;
      end
      return hit;
   endfunction

   // Combinational hazard detection, stall/issue/flush generation.
   always_comb begin
      data_haz_s = id_valid &&
                   (src_hazard(id_rs1_en, id_rs1, sb_vld_q, sb_ld_q, sb_rd_q) ||
                    src_hazard(id_rs2_en, id_rs2, sb_vld_q, sb_ld_q, sb_rd_q));
      ctrl_haz_s = (state_q == ST_WAIT);
      release_s  = ctrl_haz_s && (ex_redirect || (cnt_q == CNT_ZERO));
      // Outputs are held quiet while reset is applied.
      stall_s    = !rst && (data_haz_s || ctrl_haz_s);
      issue_s    = !rst && id_valid && !(data_haz_s || ctrl_haz_s);
      flush_s    = !rst && release_s;
   end

   assign stall          = stall_s;
   assign issue          = issue_s;
   assign flush          = flush_s;
   assign data_stall_cnt = dcnt_q;
   assign ctrl_stall_cnt = ccnt_q;

   // Scoreboard shift: the issuing instruction enters slot 0, others age.
   always_comb begin
      sb_vld_d    = sb_vld_q;
      sb_ld_d     = sb_ld_q;
      sb_rd_d     = sb_rd_q;
      // r0 is hardwired zero, so writes to it never need tracking.
      sb_vld_d[0] = issue_s && id_rd_en && (id_rd != REG_ZERO);
      sb_ld_d[0]  = id_is_load;
      sb_rd_d[0]  = id_rd;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
         sb_vld_d[i] = sb_vld_q[i-1];
         sb_ld_d[i]  = sb_ld_q[i-1];
         sb_rd_d[i]  = sb_rd_q[i-1];
      end
   end

   // Control-transfer FSM next state: block issue until redirect or timeout.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (issue_s && id_is_ctrl) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_INIT;
            end else begin
               state_d = ST_IDLE;
               cnt_d   = cnt_q;
            end
         end
         ST_WAIT: begin
            if (release_s) begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // Saturating stall counters; a control stall is never also counted as data.
   always_comb begin
      dcnt_d = dcnt_q;
      ccnt_d = ccnt_q;
      if (ctrl_haz_s) begin
         if (ccnt_q != PERF_MAX) begin
            ccnt_d = ccnt_q + PERF_ONE;
         end else begin
            ccnt_d = ccnt_q;
         end
      end else if (data_haz_s) begin
         if (dcnt_q != PERF_MAX) begin
            dcnt_d = dcnt_q + PERF_ONE;
         end else begin
            dcnt_d = dcnt_q;
         end
      end else begin
         dcnt_d = dcnt_q;
         ccnt_d = ccnt_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sb_vld_q <= {PIPE_DEPTH{1'b0}};
         sb_ld_q  <= {PIPE_DEPTH{1'b0}};
         sb_rd_q  <= {(PIPE_DEPTH*REG_AW){1'b0}};
         state_q  <= ST_IDLE;
         cnt_q    <= CNT_ZERO;
         dcnt_q   <= {CNT_W{1'b0}};
         ccnt_q   <= {CNT_W{1'b0}};
      end else begin
         sb_vld_q <= sb_vld_d;
         sb_ld_q  <= sb_ld_d;
         sb_rd_q  <= sb_rd_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dcnt_q   <= dcnt_d;
         ccnt_q   <= ccnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Two instances share one stimulus stream: dut0 without forwarding and a
//   4-bit counter width, dut1 with forwarding and a 16-bit counter width.
//   The reference model keeps an issue history indexed by cycle number and a
//   "control block started at cycle N" record, and derives every expected
//   output from those.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

   localparam int PD   = 3;
   localparam int CL   = 3;
   localparam int NCYC = 8192;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, id_valid, id_rs1_en, id_rs2_en, id_rd_en, id_is_load, id_is_ctrl, ex_redirect;
   logic [3:0] id_rs1, id_rs2, id_rd;

   logic        stall0, flush0, issue0, stall1, flush1, issue1;
   logic [3:0]  dcnt0, ccnt0;
   logic [15:0] dcnt1, ccnt1;

   hazard_scoreboard #(.REG_AW(4), .PIPE_DEPTH(PD), .FORWARD_EN(0), .CTRL_LAT(CL), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1_en(id_rs1_en), .id_rs1(id_rs1), .id_rs2_en(id_rs2_en), .id_rs2(id_rs2),
      .id_rd_en(id_rd_en), .id_rd(id_rd), .id_is_load(id_is_load), .id_is_ctrl(id_is_ctrl),
      .ex_redirect(ex_redirect), .stall(stall0), .flush(flush0), .issue(issue0),
      .data_stall_cnt(dcnt0), .ctrl_stall_cnt(ccnt0));

   hazard_scoreboard #(.REG_AW(4), .PIPE_DEPTH(PD), .FORWARD_EN(1), .CTRL_LAT(CL), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1_en(id_rs1_en), .id_rs1(id_rs1), .id_rs2_en(id_rs2_en), .id_rs2(id_rs2),
      .id_rd_en(id_rd_en), .id_rd(id_rd), .id_is_load(id_is_load), .id_is_ctrl(id_is_ctrl),
      .ex_redirect(ex_redirect), .stall(stall1), .flush(flush1), .issue(issue1),
      .data_stall_cnt(dcnt1), .ctrl_stall_cnt(ccnt1));

   // Reference model state, one entry per instance.
   int         cyc;
   int         rst_cyc [2];
   bit         hv      [2][NCYC];
   logic [3:0] hrd     [2][NCYC];
   bit         hld     [2][NCYC];
   bit         busy    [2];
   int         start   [2];
   int         exp_d   [2];
   int         exp_c   [2];
   int         cap     [2];
   int         fwd     [2];
   bit e_stall[2], e_flush[2], e_issue[2], e_dh[2], e_ch[2], e_rel[2];
   bit o_stall[2], o_flush[2], o_issue[2];

   int n_chk;
   int n_pass;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // An instruction issued `age` cycles ago is a pending write for 1..PD cycles.
   function automatic bit src_haz(input int m, input bit en, input logic [3:0] rs);
      if (!en || rs == 4'd0) return 1'b0;
      for (int age = 1; age <= PD; age++) begin
         int c;
         c = cyc - age;
         if (c >= 0 && c > rst_cyc[m] && hv[m][c] && hrd[m][c] == rs) begin
            if (fwd[m] == 0) return 1'b1;
            if (age == 1 && hld[m][c]) return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   // One clock cycle: predict, compare, advance the model at the edge.
   task automatic tick();
      #1;
      if (cyc >= NCYC - 1) begin
         $display("FAIL cycle_budget: got %0d expected below %0d", cyc, NCYC - 1);
         $fatal(1);
      end
      for (int m = 0; m < 2; m++) begin
         e_dh[m]  = id_valid && (src_haz(m, id_rs1_en, id_rs1) || src_haz(m, id_rs2_en, id_rs2));
         e_ch[m]  = busy[m];
         e_rel[m] = busy[m] && (ex_redirect || (cyc - start[m]) >= CL);
         if (rst) begin
            e_stall[m] = 1'b0; e_issue[m] = 1'b0; e_flush[m] = 1'b0;
         end else begin
            e_stall[m] = e_dh[m] || e_ch[m];
            e_issue[m] = id_valid && !e_stall[m];
            e_flush[m] = e_rel[m];
         end
      end
      o_stall[0] = stall0; o_flush[0] = flush0; o_issue[0] = issue0;
      o_stall[1] = stall1; o_flush[1] = flush1; o_issue[1] = issue1;
      check_eq("stall_f0", int'(stall0), int'(e_stall[0]));
      check_eq("flush_f0", int'(flush0), int'(e_flush[0]));
      check_eq("issue_f0", int'(issue0), int'(e_issue[0]));
      check_eq("dcnt_f0",  int'(dcnt0),  exp_d[0]);
      check_eq("ccnt_f0",  int'(ccnt0),  exp_c[0]);
      check_eq("stall_f1", int'(stall1), int'(e_stall[1]));
      check_eq("flush_f1", int'(flush1), int'(e_flush[1]));
      check_eq("issue_f1", int'(issue1), int'(e_issue[1]));
      check_eq("dcnt_f1",  int'(dcnt1),  exp_d[1]);
      check_eq("ccnt_f1",  int'(ccnt1),  exp_c[1]);
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         hv[m][cyc]  = e_issue[m] && id_rd_en && (id_rd != 4'd0);
         hrd[m][cyc] = id_rd;
         hld[m][cyc] = id_is_load;
         if (rst) begin
            rst_cyc[m] = cyc; busy[m] = 1'b0; exp_d[m] = 0; exp_c[m] = 0;
         end else begin
            if (e_ch[m]) begin
               if (exp_c[m] < cap[m]) exp_c[m]++;
            end else if (e_dh[m]) begin
               if (exp_d[m] < cap[m]) exp_d[m]++;
            end
            if (busy[m] && e_rel[m]) busy[m] = 1'b0;
            else if (!busy[m] && e_issue[m] && id_is_ctrl) begin
               busy[m] = 1'b1; start[m] = cyc;
            end
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic clr_in();
      rst = 1'b0; id_valid = 1'b0; id_rs1_en = 1'b0; id_rs2_en = 1'b0; id_rd_en = 1'b0;
      id_rs1 = 4'd0; id_rs2 = 4'd0; id_rd = 4'd0; id_is_load = 1'b0; id_is_ctrl = 1'b0;
      ex_redirect = 1'b0;
   endtask

   task automatic idle(input int n);
      clr_in();
      repeat (n) tick();
   endtask

   // Producer followed by a dependent consumer; count stall cycles before issue.
   task automatic dep_pair(input bit ld, input logic [3:0] prd, input logic [3:0] rs,
                           input bit on_rs2, input int e0, input int e1, input string tag);
      int n0, n1;
      bit d0, d1;
      n0 = 0; n1 = 0; d0 = 1'b0; d1 = 1'b0;
      idle(4);
      clr_in(); id_valid = 1'b1; id_rd_en = 1'b1; id_rd = prd; id_is_load = ld;
      tick();
      clr_in(); id_valid = 1'b1;
      if (on_rs2) begin id_rs2_en = 1'b1; id_rs2 = rs; end
      else begin id_rs1_en = 1'b1; id_rs1 = rs; end
      for (int i = 0; i < 8; i++) begin
         tick();
         if (!d0) begin if (o_stall[0]) n0++; else d0 = 1'b1; end
         if (!d1) begin if (o_stall[1]) n1++; else d1 = 1'b1; end
      end
      check_eq({tag, "_stalls_f0"}, n0, e0);
      check_eq({tag, "_stalls_f1"}, n1, e1);
   endtask

   // Control instruction followed by empty ID; count stalls and flush position.
   task automatic ctrl_test(input bit redir_first, input int e_n, input int e_fidx, input string tag);
      int n, fidx;
      n = 0; fidx = -1;
      idle(4);
      clr_in(); id_valid = 1'b1; id_is_ctrl = 1'b1;
      tick();
      clr_in();
      for (int i = 0; i < 6; i++) begin
         ex_redirect = redir_first && (i == 0);
         tick();
         if (o_stall[0]) n++;
         if (o_flush[0] && fidx < 0) fidx = i;
      end
      check_eq({tag, "_stalls"}, n, e_n);
      check_eq({tag, "_flush_idx"}, fidx, e_fidx);
   endtask

   initial begin
      n_chk = 0; n_pass = 0; cyc = 0;
      cap[0] = 15; cap[1] = 65535; fwd[0] = 0; fwd[1] = 1;
      for (int m = 0; m < 2; m++) begin
         rst_cyc[m] = -1; busy[m] = 1'b0; start[m] = 0; exp_d[m] = 0; exp_c[m] = 0;
      end
      clr_in();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset: stall/issue/flush forced low even with a valid control instruction.
      id_valid = 1'b1; id_is_ctrl = 1'b1; id_rd_en = 1'b1; id_rd = 4'd2;
      tick();

      // r0 reads and rd=0 writes never stall; own-rd read does not hazard itself.
      dep_pair(1'b0, 4'd0, 4'd0, 1'b0, 0, 0, "r0_rs1");
      dep_pair(1'b1, 4'd0, 4'd0, 1'b1, 0, 0, "r0_rs2");
      idle(4);
      clr_in(); id_valid = 1'b1; id_rs1_en = 1'b1; id_rs1 = 4'd6; id_rd_en = 1'b1; id_rd = 4'd6;
      tick();
      check_eq("own_rd_stall", int'(o_stall[0]), 0);
      check_eq("own_rd_issue", int'(o_issue[0]), 1);
      check_eq("r0_dcnt_f0", int'(dcnt0), 0);
      check_eq("r0_dcnt_f1", int'(dcnt1), 0);

      // Dependency distances with and without forwarding.
      dep_pair(1'b0, 4'd5, 4'd5, 1'b0, 3, 0, "raw_rd5");
      dep_pair(1'b1, 4'd7, 4'd7, 1'b1, 3, 1, "load_use_rd7");
      dep_pair(1'b0, 4'd7, 4'd7, 1'b1, 3, 0, "alu_rd7");

      // Control blocking: full latency, and early release by redirect.
      ctrl_test(1'b0, 3, 2, "ctrl_timeout");
      ctrl_test(1'b1, 1, 0, "ctrl_redirect");

      // Counter saturation on the 4-bit instance.
      clr_in(); rst = 1'b1; tick();
      clr_in(); id_valid = 1'b1; id_rs1_en = 1'b1; id_rs1 = 4'd9; id_rd_en = 1'b1; id_rd = 4'd9;
      repeat (40) tick();
      check_eq("sat_dcnt_f0", int'(dcnt0), 15);
      check_eq("sat_dcnt_f1", int'(dcnt1), 0);

      // Reset in the middle of a control block with a pending write.
      clr_in(); id_valid = 1'b1; id_is_ctrl = 1'b1; id_rd_en = 1'b1; id_rd = 4'd3;
      tick();
      clr_in();
      tick();
      rst = 1'b1;
      tick();
      clr_in(); id_valid = 1'b1; id_rs1_en = 1'b1; id_rs1 = 4'd3;
      #1;
      check_eq("post_rst_stall", int'(stall0), 0);
      check_eq("post_rst_flush", int'(flush0), 0);
      check_eq("post_rst_issue", int'(issue0), 1);
      check_eq("post_rst_ccnt",  int'(ccnt0), 0);
      check_eq("post_rst_dcnt",  int'(dcnt0), 0);
      tick();

      // Randomized traffic with a small register set to provoke conflicts.
      for (int i = 0; i < 1500; i++) begin
         rst         = ($urandom_range(0, 99) < 2);
         id_valid    = ($urandom_range(0, 99) < 80);
         id_rs1_en   = ($urandom_range(0, 99) < 70);
         id_rs2_en   = ($urandom_range(0, 99) < 50);
         id_rd_en    = ($urandom_range(0, 99) < 70);
         id_rs1      = 4'($urandom_range(0, 5));
         id_rs2      = 4'($urandom_range(0, 5));
         id_rd       = 4'($urandom_range(0, 5));
         id_is_load  = ($urandom_range(0, 99) < 30);
         id_is_ctrl  = ($urandom_range(0, 99) < 8);
         ex_redirect = ($urandom_range(0, 99) < 15);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
